// File: rtl/core_mem_pkg.sv
// Shared encodings for the core memory arbiter and its helpers.
// Grant selection lives here so the round-robin rule has one definition.
package core_mem_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam logic [3:0] BE_ALL = 4'hF;

  // On a tie the requester that did not win last time goes next.
  function automatic logic arb_pick(input logic i_req, input logic d_req, input logic last);
    if (i_req && d_req) return (last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    return d_req ? GNT_DATA : GNT_FETCH;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// 8-bit transaction watchdog: clear wins over enable, expired flags TIMEOUT-1.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)        cnt_q <= 8'd0;
    else if (clr_i) cnt_q <= 8'd0;
    else if (en_i)  cnt_q <= cnt_q + 8'd1;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU.
// IDLE grants, BUSY holds the latched request on mem_*, RESP pulses one ack.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          i_err_q, i_err_d, d_err_q, d_err_d;
  logic          cnt_clr, cnt_en, cnt_exp;
  logic [31:0]   rsp_data;
  logic          rsp_err;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (cnt_exp)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    i_err_d   = i_err_q;
    d_rdata_d = d_rdata_q;
    d_err_d   = d_err_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    // mem_ack beats the watchdog when both land in the same cycle.
    rsp_data  = (mem_ack && !we_q) ? mem_rdata : 32'd0;
    rsp_err   = !mem_ack;

    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = arb_pick(i_req, d_req, last_q);
          last_d  = gnt_d;
          state_d = ARB_BUSY;
          cnt_clr = 1'b1;
          if (gnt_d == GNT_DATA) begin
            addr_d  = d_addr;
            we_d    = d_we;
            be_d    = d_be;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr;
            we_d    = 1'b0;
            be_d    = BE_ALL;
            wdata_d = 32'd0;
          end
        end
      end
      ARB_BUSY: begin
        if (mem_ack || cnt_exp) begin
          state_d = ARB_RESP;
          if (gnt_q == GNT_DATA) begin
            d_rdata_d = rsp_data;
            d_err_d   = rsp_err;
          end else begin
            i_rdata_d = rsp_data;
            i_err_d   = rsp_err;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= GNT_FETCH;
      last_q    <= GNT_DATA;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      i_rdata_q <= 32'd0;
      i_err_q   <= 1'b0;
      d_rdata_q <= 32'd0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      i_err_q   <= i_err_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign mem_req   = (state_q == ARB_BUSY);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_ack   = (state_q == ARB_RESP) && (gnt_q == GNT_FETCH);
  assign d_ack   = (state_q == ARB_RESP) && (gnt_q == GNT_DATA);
  assign i_rdata = i_rdata_q;
  assign i_err   = i_err_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed + randomized bench for core_mem_arbiter with a transaction-level model.
module tb_core_mem_arbiter;

  localparam int TO = 16;
  localparam logic GF = 1'b0;
  localparam logic GD = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        i_ack, i_err, d_ack, d_err, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  // model state
  logic        last_g;
  logic [31:0] m_irdata, m_drdata;
  logic        m_ierr, m_derr;

  core_mem_arbiter #(.AW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_ack"},   32'(i_ack),   32'h0);
    chk({tag, "_i_rdata"}, i_rdata,      32'h0);
    chk({tag, "_i_err"},   32'(i_err),   32'h0);
    chk({tag, "_d_ack"},   32'(d_ack),   32'h0);
    chk({tag, "_d_rdata"}, d_rdata,      32'h0);
    chk({tag, "_d_err"},   32'(d_err),   32'h0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_we"},  32'(mem_we),  32'h0);
    chk({tag, "_mem_be"},  32'(mem_be),  32'h0);
    chk({tag, "_mem_addr"}, mem_addr,    32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata,  32'h0);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_i_rdata"}, i_rdata,    m_irdata);
    chk({tag, "_i_err"},   32'(i_err), 32'(m_ierr));
    chk({tag, "_d_rdata"}, d_rdata,    m_drdata);
    chk({tag, "_d_err"},   32'(d_err), 32'(m_derr));
  endtask

  task automatic model_reset();
    last_g   = GD;
    m_irdata = 32'h0; m_drdata = 32'h0;
    m_ierr   = 1'b0;  m_derr   = 1'b0;
  endtask

  task automatic rand_fields();
    i_addr  = $urandom; d_addr = $urandom; d_wdata = $urandom;
    d_we    = 1'($urandom); d_be = 4'($urandom);
  endtask

  // Runs one transaction from an IDLE cycle with requests already driven.
  // dly = BUSY cycle index of mem_ack; dly >= TO means memory never answers.
  task automatic txn(input string tag, input int dly, input logic [31:0] rd, input logic keep);
    logic g, ewe, ee;
    logic [31:0] ea, ewd, er;
    logic [3:0] ebe;
    bit done;
    int c;
    if (i_req && d_req) g = (last_g == GD) ? GF : GD;
    else                g = d_req ? GD : GF;
    last_g = g;
    if (g == GD) begin ea = d_addr; ewe = d_we; ebe = d_be; ewd = d_wdata; end
    else         begin ea = i_addr; ewe = 1'b0; ebe = 4'hF; ewd = 32'h0; end
    tick();
    c = 0; done = 0;
    while (!done) begin
      chk({tag, "_busy_req"},   32'(mem_req), 32'h1);
      chk({tag, "_busy_addr"},  mem_addr,     ea);
      chk({tag, "_busy_we"},    32'(mem_we),  32'(ewe));
      chk({tag, "_busy_be"},    32'(mem_be),  32'(ebe));
      chk({tag, "_busy_wdata"}, mem_wdata,    ewd);
      chk({tag, "_busy_acks"},  32'({i_ack, d_ack}), 32'h0);
      rand_fields();  // requester fields must not leak into a live transaction
      mem_ack   = (c == dly);
      mem_rdata = (c == dly) ? rd : $urandom;
      done = (c == dly) || (c == TO - 1);
      tick();
      mem_ack = 1'b0;
      c++;
    end
    if (dly < TO) begin er = ewe ? 32'h0 : rd; ee = 1'b0; end
    else          begin er = 32'h0;            ee = 1'b1; end
    if (g == GD) begin m_drdata = er; m_derr = ee; end
    else         begin m_irdata = er; m_ierr = ee; end
    chk({tag, "_resp_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_resp_i_ack"},   32'(i_ack),   32'(g == GF));
    chk({tag, "_resp_d_ack"},   32'(d_ack),   32'(g == GD));
    chk_held({tag, "_resp"});
    if (!keep) begin
      if (g == GF) i_req = 1'b0;
      else         d_req = 1'b0;
    end
    tick();
    chk({tag, "_idle_acks"},    32'({i_ack, d_ack}), 32'h0);
    chk({tag, "_idle_mem_req"}, 32'(mem_req),        32'h0);
    chk_held({tag, "_idle"});
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_we = 1'b0; d_be = 4'h0;
    model_reset();
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // fetch only, memory answers in the first BUSY cycle
    i_req = 1'b1; i_addr = 32'h100;
    txn("fetch", 0, 32'h0000_0013, 1'b0);

    // tie right after reset: fetch first, then the store
    rst = 1'b1; tick(); rst = 1'b0; model_reset(); tick();
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    txn("tie_f", 1, 32'h0000_0093, 1'b0);
    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    txn("tie_d", 0, 32'hCAFE_F00D, 1'b0);

    // sustained contention: six back-to-back transactions must alternate
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 6; n++) begin
      rand_fields();
      txn("sustain", int'($urandom_range(0, 3)), $urandom, 1'b1);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // watchdog expiry on a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    txn("timeout", TO, 32'h0, 1'b0);

    // ack lands exactly in the expiry cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304; d_be = 4'hF;
    txn("boundary", TO - 1, 32'h0000_0055, 1'b0);

    // reset in the middle of a fetch, then a stray mem_ack in IDLE
    i_req = 1'b1; i_addr = 32'h400;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; i_req = 1'b0; model_reset();
    chk_all_zero("midrst");
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("stray_i_ack",   32'(i_ack),   32'h0);
    chk("stray_mem_req", 32'(mem_req), 32'h0);
    tick();
    chk("stray_i_ack2",  32'(i_ack),   32'h0);
    chk("stray_i_rdata", i_rdata,      32'h0);
    i_req = 1'b1; d_req = 1'b1; rand_fields();
    txn("rst_tie_f", 0, 32'hA5A5_0001, 1'b0);
    rand_fields();
    txn("rst_tie_d", 2, 32'hA5A5_0002, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int dly;
      if ($urandom_range(0, 1) == 1) i_req = 1'b1;
      if ($urandom_range(0, 1) == 1) d_req = 1'b1;
      if (!i_req && !d_req) d_req = 1'b1;
      rand_fields();
      dly = int'($urandom_range(0, TO + 3));
      txn("rand", dly, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
